fifo_put_arbiter: RTL and testbench

//   Shares one FIFO write port (put/put_data/full) among NUM_REQ producers.

---
 rtl/fifo_put_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_put_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_put_arbiter.sv
// Shares one FIFO write port among NUM_REQ producers. Arbitration is round-robin
// with packet lock; grant/put/data are combinational so a beat lands in the FIFO the same cycle.
module fifo_put_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       grant,
    input  logic                     fifo_full,
    output logic                     fifo_put,
    output logic [WIDTH-1:0]         fifo_put_data,
    output logic                     busy,
    output logic [15:0]              drop_cnt
);
    // state | meaning
    // IDLE  | no packet open; winner is first requester scanning from ptr
    // LOCK  | owner holds the port until it transfers a beat with last=1

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   rr_winner, winner, winner_inc;
    logic [SUM_W-1:0]   cand;
    logic               accept, beat_last;
    logic [WIDTH-1:0]   data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
        assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
    end

    // Scan from the far end back toward ptr so the nearest requester wins last.
    always_comb begin
        rr_winner = ptr;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + SUM_W'(k);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                rr_winner = cand[IDX_W-1:0];
            end
        end
    end

    assign winner     = (state == LOCK) ? owner : rr_winner;
    assign winner_inc = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign accept     = req[winner] & ~fifo_full;
    assign beat_last  = req_last[winner];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (beat_last) begin
                        ptr_nxt = winner_inc;
                    end else begin
                        state_nxt = LOCK;
                        owner_nxt = winner;
                    end
                end
                LOCK: begin
                    if (beat_last) begin
                        state_nxt = IDLE;
                        ptr_nxt   = winner_inc;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is held, independent of the inputs.
    always_comb begin
        grant         = '0;
        fifo_put      = 1'b0;
        fifo_put_data = '0;
        busy          = 1'b0;
        if (!rst) begin
            fifo_put      = accept;
            grant         = accept ? (NUM_REQ'(1) << winner) : '0;
            fifo_put_data = data_arr[winner];
            busy          = (state == LOCK);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if ((|req) && fifo_full && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_put_arbiter.sv
// Bench for fifo_put_arbiter: directed scenarios then random producers, with a
// queue scoreboard fed by a behavioural arbitration model.
module tb_fifo_put_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     req_last = '0;
    logic [N*W-1:0]   req_data = '0;
    logic             fifo_full = 1'b0;
    logic [N-1:0]     grant;
    logic             fifo_put;
    logic [W-1:0]     fifo_put_data;
    logic             busy;
    logic [15:0]      drop_cnt;

    fifo_put_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
        .grant(grant), .fifo_full(fifo_full), .fifo_put(fifo_put),
        .fifo_put_data(fifo_put_data), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] g;
        logic [W-1:0] d;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;

    // producer-side view of the inputs
    logic [N-1:0] r_req = '0;
    logic [N-1:0] r_last = '0;
    logic [W-1:0] r_data [N];

    // reference model
    int           m_ptr = 0;
    int           m_owner = 0;
    bit           m_lock = 0;
    int           m_drop = 0;
    bit           exp_busy = 0;
    int           exp_drop = 0;
    bit           last_acc = 0;
    int           last_w = 0;

    int           t3_g [4] = '{2, 2, 2, 4};
    int           t3_b [4] = '{0, 1, 1, 0};
    int           t5_g [6] = '{8, 0, 0, 8, 8, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_lock = 0; m_drop = 0;
        exp_busy = 0; exp_drop = 0;
        exp_q.delete();
    endtask

    // One clock of stimulus: apply inputs just after the edge and predict the cycle.
    task automatic step(input logic f);
        int  w;
        bit  acc;
        @(posedge clk); #1;
        req       = r_req;
        req_last  = r_last;
        fifo_full = f;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = r_data[i];
        exp_busy = m_lock;
        exp_drop = m_drop;
        w = -1;
        if (m_lock) begin
            w = m_owner;
        end else begin
            for (int k = 0; k < N; k++)
                if (w < 0 && r_req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        acc = 0;
        if (w >= 0) acc = r_req[w] && !f;
        if (r_req != '0 && f && m_drop < 65535) m_drop++;
        last_acc = acc;
        last_w   = w;
        if (acc) begin
            exp_q.push_back('{g: N'(1) << w, d: r_data[w]});
            if (m_lock) begin
                if (r_last[w]) begin
                    m_lock = 0;
                    m_ptr  = (w + 1) % N;
                end
            end else if (r_last[w]) begin
                m_ptr = (w + 1) % N;
            end else begin
                m_lock  = 1;
                m_owner = w;
            end
            r_data[w] = $urandom;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_put", 32'(fifo_put), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_data", fifo_put_data, 32'd0);
        end else begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
            if (fifo_put) begin
                chk("put_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("sb_grant", 32'(grant), 32'(mon_e.g));
                    chk("sb_data", fifo_put_data, mon_e.d);
                end
            end else begin
                chk("idle_grant", 32'(grant), 32'd0);
            end
            chk("missing_put", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    end

    initial begin
        for (int i = 0; i < N; i++) r_data[i] = $urandom;
        model_reset();

        // reset holds outputs low even with all requests up
        req = '1; req_last = '1;
        #1;
        chk("t1_rst_grant", 32'(grant), 32'd0);
        chk("t1_rst_put", 32'(fifo_put), 32'd0);
        req = '0; req_last = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // single-beat round robin
        r_req = '1; r_last = '1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0); #1;
            chk("t1_grant", 32'(grant), 32'(1 << (i % 4)));
        end

        // fairness between producers 1 and 3
        r_req = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            step(1'b0); #1;
            chk("t2_grant", 32'(grant), (i % 2 == 0) ? 32'd2 : 32'd8);
        end

        // move ptr to 1, then producer 1 sends a 3-beat packet
        r_req = 4'b0001; r_last = 4'b0001;
        step(1'b0); #1;
        chk("t3_pre", 32'(grant), 32'd1);
        r_req = 4'b0111; r_last = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) r_last = 4'b0111;
            step(1'b0); #1;
            chk("t3_grant", 32'(grant), 32'(t3_g[i]));
            chk("t3_busy", 32'(busy), 32'(t3_b[i]));
            if (i == 3) r_req = 4'b0001;
        end
        step(1'b0); #1;
        chk("t3_post", 32'(grant), 32'd1);

        // full backpressure on producer 2
        r_req = 4'b0100; r_last = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step(1'b1); #1;
            chk("t4_full_grant", 32'(grant), 32'd0);
            chk("t4_full_put", 32'(fifo_put), 32'd0);
        end
        step(1'b0); #1;
        chk("t4_grant", 32'(grant), 32'd4);
        chk("t4_drop", 32'(drop_cnt), 32'd5);

        // bubble while producer 3 owns the port
        r_req = 4'b1001; r_last = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) r_req = 4'b0001;
            if (i == 3) r_req = 4'b1001;
            if (i == 4) r_last = 4'b1001;
            if (i == 5) r_req = 4'b0001;
            step(1'b0); #1;
            chk("t5_grant", 32'(grant), 32'(t5_g[i]));
        end
        r_req = '0;
        step(1'b0);

        // async reset in the middle of a packet
        r_req = 4'b0010; r_last = 4'b0000;
        step(1'b0); #1;
        chk("t6_start", 32'(grant), 32'd2);
        r_req = 4'b0011;
        step(1'b0); #1;
        chk("t6_owner", 32'(grant), 32'd2);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_put", 32'(fifo_put), 32'd0);
        r_req = '0; req = '0; req_last = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        r_req = 4'b0011; r_last = 4'b0011;
        step(1'b0); #1;
        chk("t6_restart", 32'(grant), 32'd1);
        chk("t6_busy_after", 32'(busy), 32'd0);
        r_req = 4'b0010;
        step(1'b0);
        r_req = '0; r_last = '0;

        // random producers with occasional full
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!r_req[i] && $urandom_range(0, 1) == 0) begin
                    r_req[i]  = 1'b1;
                    r_last[i] = ($urandom_range(0, 2) == 0);
                end
            end
            step($urandom_range(0, 4) == 0);
            if (last_acc) r_req[last_w] = 1'b0;
        end
        r_req = '0;
        step(1'b0);
        step(1'b0);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
